// File: rtl/lab_nios_system_pulse_counter.sv
// Wheel-sensor pulse counter with an Avalon-MM slave interface (16-bit data).
// Rising edges on pulse_in are counted within windows delimited by window_tick.
// At each boundary the finished count is pushed into a small sample FIFO.
// The Nios II drains the FIFO, and irq flags pending samples or a lost sample.
`timescale 1ns/1ps

module lab_nios_system_pulse_counter #(
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        pulse_in,
  input  logic        window_tick,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [LW-1:0]    LVL_FULL = LW'(FIFO_DEPTH);

  logic             sync1_r;
  logic             sync2_r;
  logic             prev_r;
  logic             edge_s;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             enable_r;
  logic             enable_next_s;
  logic             irq_en_r;
  logic             irq_en_next_s;
  logic             overflow_r;
  logic             overflow_next_s;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    wr_ptr_next_s;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    rd_ptr_next_s;
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_next_s;
  logic [CNT_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic             rd_s;
  logic             wr_s;
  logic             ctrl_wr_s;
  logic             clear_s;
  logic             ovf_clr_s;
  logic             push_req_s;
  logic             do_push_s;
  logic             pop_s;
  logic             full_s;
  logic             nonempty_s;
  logic             mem_we_s;
  logic             irq_next_s;
  logic [15:0]      rdata_mux_s;
  logic             unused_s;

  assign rd_s       = chipselect & ~read_n;
  assign wr_s       = chipselect & ~write_n;
  assign ctrl_wr_s  = wr_s & (address == 3'd1);
  assign clear_s    = ctrl_wr_s & writedata[2];
  assign ovf_clr_s  = wr_s & (address == 3'd0);
  assign nonempty_s = (level_r != {LW{1'b0}});
  assign full_s     = (level_r == LVL_FULL);
  assign edge_s     = sync2_r & ~prev_r;
  // The pop can never coincide with a clear: they need different addresses.
  assign pop_s      = rd_s & (address == 3'd2) & nonempty_s;
  assign push_req_s = window_tick & enable_r;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push_s  = push_req_s & (~full_s | pop_s);
  assign mem_we_s   = do_push_s & ~clear_s;
  assign unused_s   = ^writedata[15:3];

  // Register read multiplexer; sampled into readdata on every clock.
  always_comb begin
    rdata_mux_s = 16'd0;
    case (address)
      3'd0: rdata_mux_s = {13'd0, enable_r, overflow_r, nonempty_s};
      3'd1: rdata_mux_s = {14'd0, irq_en_r, enable_r};
      3'd2: begin
        if (nonempty_s) begin
          rdata_mux_s = 16'(fifo_mem_r[rd_ptr_r]);
        end else begin
          rdata_mux_s = 16'd0;
        end
      end
      3'd3: rdata_mux_s = 16'(level_r);
      3'd4: rdata_mux_s = 16'(count_r);
      default: rdata_mux_s = 16'd0;
    endcase
  end

  // Next-state for control, window count, FIFO pointers/occupancy, overflow and irq.
  always_comb begin
    count_next_s    = count_r;
    wr_ptr_next_s   = wr_ptr_r;
    rd_ptr_next_s   = rd_ptr_r;
    level_next_s    = level_r;
    overflow_next_s = overflow_r;
    if (ctrl_wr_s) begin
      enable_next_s = writedata[0];
      irq_en_next_s = writedata[1];
    end else begin
      enable_next_s = enable_r;
      irq_en_next_s = irq_en_r;
    end
    if (clear_s) begin
      count_next_s    = {CNT_W{1'b0}};
      wr_ptr_next_s   = {AW{1'b0}};
      rd_ptr_next_s   = {AW{1'b0}};
      level_next_s    = {LW{1'b0}};
      overflow_next_s = 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_next_s = wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_next_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_next_s = rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_next_s = rd_ptr_r;
      end
      case ({do_push_s, pop_s})
        2'b10:   level_next_s = level_r + LW'(1);
        2'b01:   level_next_s = level_r - LW'(1);
        default: level_next_s = level_r;
      endcase
      // A status write outranks a sample lost in the same cycle.
      if (ovf_clr_s) begin
        overflow_next_s = 1'b0;
      end else if (push_req_s && full_s && !pop_s) begin
        overflow_next_s = 1'b1;
      end else begin
        overflow_next_s = overflow_r;
      end
      // An edge in the tick cycle opens the new window with a count of one.
      if (enable_r) begin
        if (window_tick) begin
          count_next_s = edge_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (edge_s && (count_r != CNT_MAX)) begin
          count_next_s = count_r + CNT_W'(1);
        end else begin
          count_next_s = count_r;
        end
      end else begin
        count_next_s = count_r;
      end
    end
    irq_next_s = irq_en_next_s & ((level_next_s != {LW{1'b0}}) | overflow_next_s);
  end

  // State, synchroniser and registered output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r    <= 1'b0;
      sync2_r    <= 1'b0;
      prev_r     <= 1'b0;
      count_r    <= {CNT_W{1'b0}};
      enable_r   <= 1'b0;
      irq_en_r   <= 1'b0;
      overflow_r <= 1'b0;
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      readdata   <= 16'd0;
      irq        <= 1'b0;
    end else begin
      sync1_r    <= pulse_in;
      sync2_r    <= sync1_r;
      prev_r     <= sync2_r;
      count_r    <= count_next_s;
      enable_r   <= enable_next_s;
      irq_en_r   <= irq_en_next_s;
      overflow_r <= overflow_next_s;
      wr_ptr_r   <= wr_ptr_next_s;
      rd_ptr_r   <= rd_ptr_next_s;
      level_r    <= level_next_s;
      readdata   <= rdata_mux_s;
      irq        <= irq_next_s;
    end
  end

  // Sample storage; stale entries are never visible because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (!reset && mem_we_s) begin
      fifo_mem_r[wr_ptr_r] <= count_r;
    end
  end

endmodule

// File: tb/tb_lab_nios_system_pulse_counter.sv
// Scoreboard bench for lab_nios_system_pulse_counter: two instances (16-bit and
// 4-bit counts) share one stimulus stream and one abstract reference model.
`timescale 1ns/1ps

module tb_lab_nios_system_pulse_counter;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = 3'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [15:0] writedata = 16'd0;
  logic        pulse_in = 1'b0;
  logic        window_tick = 1'b0;
  logic [15:0] rdata16;
  logic [15:0] rdata4;
  logic        irq16;
  logic        irq4;

  lab_nios_system_pulse_counter u_dut16 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata16),
    .pulse_in(pulse_in), .window_tick(window_tick), .irq(irq16)
  );

  lab_nios_system_pulse_counter #(.CNT_W(4), .FIFO_DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(rdata4),
    .pulse_in(pulse_in), .window_tick(window_tick), .irq(irq4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d16;
    logic [15:0] d4;
    logic        irq;
    logic [2:0]  addr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: raw (unsaturated) edge count per window, FIFO of raw samples.
  int   m_cnt;
  int   m_fifo[$];
  bit   m_en, m_ie, m_ovf;
  bit   m_h0, m_h1, m_h2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // One bus cycle: drive inputs, advance the model, queue the expected read result.
  task automatic step(input bit rst, input bit cs, input bit rdn, input bit wrn,
                      input logic [2:0] a, input logic [15:0] wd, input bit p, input bit t,
                      input int k16, input int k4);
    bit   rd, wr, ev, clr, en_old, ne;
    int   rv;
    exp_t e;
    @(negedge clk);
    reset = rst; chipselect = cs; read_n = rdn; write_n = wrn;
    address = a; writedata = wd; pulse_in = p; window_tick = t;
    if (rst) begin
      m_h0 = 0; m_h1 = 0; m_h2 = 0; m_cnt = 0; m_fifo.delete();
      m_en = 0; m_ie = 0; m_ovf = 0;
      return;
    end
    rd = cs && !rdn;
    wr = cs && !wrn;
    ev = m_h1 && !m_h2;
    m_h2 = m_h1; m_h1 = m_h0; m_h0 = p;
    ne = (m_fifo.size() != 0);
    case (a)
      3'd0: rv = int'({m_en, m_ovf, ne});
      3'd1: rv = int'({m_ie, m_en});
      3'd2: rv = ne ? m_fifo[0] : 0;
      3'd3: rv = m_fifo.size();
      3'd4: rv = m_cnt;
      default: rv = 0;
    endcase
    e.addr = a;
    e.d16  = (a == 3'd2 || a == 3'd4) ? 16'(sat(rv, 16)) : 16'(rv);
    e.d4   = (a == 3'd2 || a == 3'd4) ? 16'(sat(rv, 4)) : 16'(rv);
    en_old = m_en;
    clr    = wr && (a == 3'd1) && wd[2];
    if (clr) begin
      m_fifo.delete(); m_cnt = 0; m_ovf = 0;
    end else begin
      if (rd && a == 3'd2 && m_fifo.size() != 0) void'(m_fifo.pop_front());
      if (en_old && t) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(m_cnt);
        else m_ovf = 1;
        m_cnt = ev ? 1 : 0;
      end else if (en_old && ev) begin
        m_cnt++;
      end
      if (wr && a == 3'd0) m_ovf = 0;
    end
    if (wr && a == 3'd1) begin
      m_en = wd[0];
      m_ie = wd[1];
    end
    if (rd) begin
      e.irq = m_ie && (m_fifo.size() != 0 || m_ovf);
      if (k16 >= 0) e.d16 = 16'(k16);
      if (k4 >= 0)  e.d4  = 16'(k4);
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 1, 3'd0, 16'd0, 0, 0, -1, -1);
  endtask

  task automatic pls(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 1, 1, 3'd0, 16'd0, 1, 0, -1, -1);
      step(0, 0, 1, 1, 3'd0, 16'd0, 0, 0, -1, -1);
    end
  endtask

  task automatic tick();
    step(0, 0, 1, 1, 3'd0, 16'd0, 0, 1, -1, -1);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    step(0, 1, 1, 0, a, d, 0, 0, -1, -1);
  endtask

  task automatic rd(input logic [2:0] a, input int k16, input int k4);
    step(0, 1, 0, 1, a, 16'd0, 0, 0, k16, k4);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 3'd0, 16'd0, 0, 0, -1, -1);
  endtask

  // Monitor: one cycle after every read strobe, compare both instances to the queue head.
  exp_t mon_e;
  always @(posedge clk) begin
    if (reset === 1'b0 && chipselect === 1'b1 && read_n === 1'b0) begin
      #1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("rd%0d_data16", mon_e.addr), 32'(rdata16), 32'(mon_e.d16));
        chk($sformatf("rd%0d_data4", mon_e.addr),  32'(rdata4),  32'(mon_e.d4));
        chk($sformatf("rd%0d_irq16", mon_e.addr),  32'(irq16),   32'(mon_e.irq));
        chk($sformatf("rd%0d_irq4", mon_e.addr),   32'(irq4),    32'(mon_e.irq));
      end
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    logic [15:0] d;
    logic [2:0]  a;
    int          r;
    bit          p, t;

    do_reset();
    @(posedge clk); #1;
    chk("reset_readdata16", 32'(rdata16), 32'd0);
    chk("reset_readdata4",  32'(rdata4),  32'd0);
    chk("reset_irq16",      32'(irq16),   32'd0);
    chk("reset_irq4",       32'(irq4),    32'd0);
    rd(3'd0, 0, 0); rd(3'd1, 0, 0); rd(3'd3, 0, 0); rd(3'd4, 0, 0); rd(3'd2, 0, 0);

    // T1: five pulses, one window
    wr(3'd1, 16'd1); pls(5); idle(4); tick(); idle(1);
    rd(3'd3, 1, 1); rd(3'd2, 5, 5); rd(3'd3, 0, 0); rd(3'd4, 0, 0);

    // T2: edge coincident with tick belongs to the new window
    pls(3); idle(4);
    step(0, 0, 1, 1, 3'd0, 16'd0, 1, 0, -1, -1);
    step(0, 0, 1, 1, 3'd0, 16'd0, 0, 0, -1, -1);
    tick(); idle(1);
    rd(3'd2, 3, 3); rd(3'd4, 1, 1); rd(3'd3, 0, 0);

    // T3: overflow and interrupt
    wr(3'd1, 16'd3);
    for (int i = 0; i < 5; i++) begin tick(); idle(1); end
    rd(3'd3, 4, 4); rd(3'd0, 7, 7);
    rd(3'd2, 1, 1); rd(3'd2, 0, 0); rd(3'd2, 0, 0); rd(3'd2, 0, 0);
    rd(3'd0, 6, 6); wr(3'd0, 16'd0); rd(3'd0, 4, 4);

    // T4: saturation of the narrow instance
    wr(3'd1, 16'd5); pls(20); idle(4); tick(); idle(1);
    rd(3'd2, 20, 15); rd(3'd4, 0, 0);

    // T5: clear strobe with tick and edge in the same cycle
    pls(2); idle(4); tick(); pls(1); idle(4); tick(); idle(1);
    rd(3'd3, 2, 2);
    step(0, 0, 1, 1, 3'd0, 16'd0, 1, 0, -1, -1);
    step(0, 0, 1, 1, 3'd0, 16'd0, 0, 0, -1, -1);
    step(0, 1, 1, 0, 3'd1, 16'd7, 0, 1, -1, -1);
    idle(1);
    rd(3'd3, 0, 0); rd(3'd4, 0, 0); rd(3'd0, 4, 4);

    // T6: disabled counter ignores edges and ticks
    pls(2); idle(4); rd(3'd4, 2, 2);
    wr(3'd1, 16'd0); pls(3); tick(); pls(2); tick(); idle(4);
    rd(3'd4, 2, 2); rd(3'd3, 0, 0); rd(3'd2, 0, 0); rd(3'd0, 0, 0);

    // Randomized phase checked against the model
    do_reset();
    wr(3'd1, 16'(1 + 2 * $urandom_range(0, 1)));
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      p = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 29) == 0);
      if (r == 0 && $urandom_range(0, 9) == 0) begin
        step(1, 0, 1, 1, 3'd0, 16'd0, p, t, -1, -1);
      end else if (r < 20) begin
        a = ($urandom_range(0, 3) == 0) ? 3'd2 : 3'($urandom_range(0, 5));
        step(0, 1, 0, 1, a, 16'd0, p, t, -1, -1);
      end else if (r < 25) begin
        a = 3'($urandom_range(0, 5));
        d = 16'($urandom);
        if (a == 3'd1) begin
          d[0] = ($urandom_range(0, 7) != 0);
          d[2] = ($urandom_range(0, 15) == 0);
        end
        step(0, 1, 1, 0, a, d, p, t, -1, -1);
      end else begin
        step(0, 0, 1, 1, 3'd0, 16'd0, p, t, -1, -1);
      end
    end
    idle(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
